// File: rtl/sha_arbiter_if.sv
// sha_arbiter_if: request, engine and response signals around sha_arbiter.
// The arbiter uses the slave view; requesters, engine and bench use master.
interface sha_arbiter_if #(
    parameter int NREQ = 4,
    parameter int NL   = 64,
    parameter int NK   = 256
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      Req;
    logic [NREQ*NL*8-1:0] Msg;
    logic [NREQ-1:0]      Gnt;
    logic [NL*8-1:0]      Sha_Data;
    logic                 Sha_Enable;
    logic [NK-1:0]        Sha_Hash;
    logic                 Sha_Ready;
    logic                 Resp_Valid;
    logic [IDW-1:0]       Resp_Id;
    logic [NK-1:0]        Resp_Hash;
    logic                 Resp_Error;
    logic                 Resp_Ack;
    logic                 Busy;

    modport slave (
        input  Req, Msg, Sha_Hash, Sha_Ready, Resp_Ack,
        output Gnt, Sha_Data, Sha_Enable, Resp_Valid, Resp_Id, Resp_Hash,
               Resp_Error, Busy
    );

    modport master (
        output Req, Msg, Sha_Hash, Sha_Ready, Resp_Ack,
        input  Gnt, Sha_Data, Sha_Enable, Resp_Valid, Resp_Id, Resp_Hash,
               Resp_Error, Busy
    );
endinterface

// File: rtl/sha_arbiter.sv
// sha_arbiter: round-robin sharing of one SHA engine among NREQ requesters.
// The granted message is latched locally so the requester can drop Req
// right after its Gnt pulse; the result (or a timeout error) is returned
// on a valid/ack channel tagged with the requester index.
module sha_arbiter #(
    parameter int NREQ    = 4,
    parameter int NL      = 64,
    parameter int NK      = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    sha_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] ID_LAST    = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [IDW-1:0]    ptr_r;
    logic [IDW-1:0]    id_r;
    logic [IDW-1:0]    sel_s;
    logic [IDW-1:0]    idx_s;
    int                sum_s;
    logic              found_s;
    logic [NL*8-1:0]   msg_sel_s;
    logic [TW-1:0]     timer_r;
    logic [NL*8-1:0]   buf_r;
    logic [NREQ-1:0]   gnt_r;
    logic              enable_r;
    logic              busy_r;
    logic              resp_valid_r;
    logic              resp_error_r;
    logic [IDW-1:0]    resp_id_r;
    logic [NK-1:0]     resp_hash_r;
    logic              grant_s;
    logic              done_s;
    logic              timeout_s;
    logic              ack_s;

    // Round-robin search: first asserted Req at ptr, ptr+1, ... wrapping.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        idx_s   = '0;
        sum_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s = int'(ptr_r) + k;
            idx_s = (sum_s >= NREQ) ? IDW'(sum_s - NREQ) : IDW'(sum_s);
            if (!found_s && bus.Req[idx_s]) begin
                found_s = 1'b1;
                sel_s   = idx_s;
            end else begin
                sel_s   = sel_s;
            end
        end
    end

    // Message mux: slice of Msg belonging to the selected requester.
    always_comb begin
        msg_sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_s == IDW'(i)) begin
                msg_sel_s = bus.Msg[i*NL*8 +: NL*8];
            end else begin
                msg_sel_s = msg_sel_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-cycle event strobes; Ready beats timeout.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        done_s       = 1'b0;
        timeout_s    = 1'b0;
        ack_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    grant_s      = 1'b1;
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                state_next_s = BUSY;
            end
            BUSY: begin
                if (bus.Sha_Ready) begin
                    done_s       = 1'b1;
                    state_next_s = RESP;
                end else if (timer_r == TIMER_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = BUSY;
                end
            end
            RESP: begin
                if (bus.Resp_Ack) begin
                    ack_s        = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: capture, pointer, timer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r        <= '0;
            id_r         <= '0;
            buf_r        <= '0;
            gnt_r        <= '0;
            enable_r     <= 1'b0;
            busy_r       <= 1'b0;
            timer_r      <= '0;
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            resp_id_r    <= '0;
            resp_hash_r  <= '0;
        end else begin
            gnt_r    <= '0;
            enable_r <= 1'b0;
            busy_r   <= (state_next_s != IDLE);
            if (grant_s) begin
                buf_r    <= msg_sel_s;
                id_r     <= sel_s;
                ptr_r    <= (sel_s == ID_LAST) ? '0 : sel_s + IDW'(1);
                gnt_r    <= NREQ'(1) << sel_s;
                enable_r <= 1'b1;
            end
            if (state_r == START) begin
                timer_r <= '0;
            end else if (state_r == BUSY) begin
                timer_r <= timer_r + TW'(1);
            end
            if (done_s) begin
                resp_hash_r  <= bus.Sha_Hash;
                resp_error_r <= 1'b0;
                resp_valid_r <= 1'b1;
                resp_id_r    <= id_r;
            end else if (timeout_s) begin
                resp_hash_r  <= '0;
                resp_error_r <= 1'b1;
                resp_valid_r <= 1'b1;
                resp_id_r    <= id_r;
            end else if (ack_s) begin
                resp_valid_r <= 1'b0;
                resp_error_r <= 1'b0;
            end
        end
    end

    assign bus.Gnt        = gnt_r;
    assign bus.Sha_Data   = buf_r;
    assign bus.Sha_Enable = enable_r;
    assign bus.Busy       = busy_r;
    assign bus.Resp_Valid = resp_valid_r;
    assign bus.Resp_Error = resp_error_r;
    assign bus.Resp_Id    = resp_id_r;
    assign bus.Resp_Hash  = resp_hash_r;
endmodule
